// File: rtl/note_sequencer.sv
// Steps a song's note table in an external synchronous ROM and holds each note for its beat count.
// Latency: a new note appears 2 cycles after its fetch starts; song_end is registered, 1 cycle after the END state.
// Backpressure: none; pause freezes the beat timer and start restarts playback from any state.
module note_sequencer #(
    parameter int NOTE_W         = 4,
    parameter int DUR_W          = 4,
    parameter int IDX_W          = 6,
    parameter int TICKS_PER_BEAT = 12500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                select,
    input  logic                      start,
    input  logic                      pause,
    output logic [IDX_W+1:0]          rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]   rom_data,
    output logic [NOTE_W-1:0]         note,
    output logic                      playing,
    output logic                      song_end
);

    localparam int                TICK_W    = $clog2(TICKS_PER_BEAT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = '1;
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [DUR_W-1:0]  BEAT_ONE  = DUR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_END
    } state_t;

    state_t              r_state;
    logic [1:0]          r_song;
    logic [IDX_W-1:0]    r_index;
    logic [TICK_W-1:0]   r_tick;
    logic [DUR_W-1:0]    r_beat;
    logic [NOTE_W-1:0]   r_note;
    logic                r_playing;
    logic                r_song_end;

    logic [NOTE_W-1:0]   w_rom_note;
    logic [DUR_W-1:0]    w_rom_dur;
    logic                w_beat_done;
    logic                w_note_done;

    assign w_rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur   = rom_data[DUR_W-1:0];
    assign w_beat_done = (r_tick == TICK_LAST);
    assign w_note_done = w_beat_done && (r_beat == BEAT_ONE);

    assign rom_addr = {r_song, r_index};
    assign note     = r_note;
    assign playing  = r_playing;
    assign song_end = r_song_end;

    // Playback FSM: start restarts from any state and suppresses the end pulse of an aborted song.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_song     <= 2'd0;
            r_index    <= '0;
            r_tick     <= '0;
            r_beat     <= '0;
            r_note     <= '0;
            r_playing  <= 1'b0;
            r_song_end <= 1'b0;
        end else begin
            r_song_end <= 1'b0;
            if (start) begin
                r_song  <= select;
                r_index <= '0;
                r_tick  <= '0;
                r_state <= S_FETCH;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    // Address is presented this cycle; ROM word arrives next cycle.
                    S_FETCH: begin
                        r_state <= S_WAIT;
                    end
                    // Previous note keeps sounding until the new word is decoded.
                    S_WAIT: begin
                        if (w_rom_dur == '0) begin
                            r_state <= S_END;
                        end else begin
                            r_note    <= w_rom_note;
                            r_beat    <= w_rom_dur;
                            r_tick    <= '0;
                            r_playing <= 1'b1;
                            r_state   <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (!pause) begin
                            if (w_beat_done) begin
                                r_tick <= '0;
                                r_beat <= r_beat - BEAT_ONE;
                            end else begin
                                r_tick <= r_tick + TICK_ONE;
                            end
                            // A full table has no marker, so the last slot ends the song.
                            if (w_note_done) begin
                                if (r_index == IDX_LAST) begin
                                    r_state <= S_END;
                                end else begin
                                    r_index <= r_index + IDX_ONE;
                                    r_state <= S_FETCH;
                                end
                            end
                        end
                    end
                    S_END: begin
                        r_song_end <= 1'b1;
                        r_note     <= '0;
                        r_playing  <= 1'b0;
                        r_index    <= '0;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Randomised bench for note_sequencer against a per-song timeline model.
// Latency: expected traces are indexed from the edge that samples start.
// Backpressure: pause patterns are fixed before each run so the model can stretch notes.
module tb_note_sequencer;

    localparam int T    = 4;
    localparam int MAXC = 512;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] select;
    logic       start;
    logic       pause;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] note;
    logic       playing;
    logic       song_end;

    logic [7:0]  rom_mem [256];
    logic [13:0] e_vec [MAXC];
    logic [13:0] o_vec [MAXC];
    bit          pz [MAXC];
    int          cur_note;
    int          cur_play;
    int          tests  = 0;
    int          failed = 0;

    note_sequencer #(
        .NOTE_W(4), .DUR_W(4), .IDX_W(6), .TICKS_PER_BEAT(T)
    ) dut (
        .clk(clk), .reset(reset), .select(select), .start(start), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .note(note), .playing(playing), .song_end(song_end)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    function automatic void put(int c, int n, int p, int e, int a);
        if (c < MAXC) e_vec[c] = {8'(a), 4'(n), 1'(p), 1'(e)};
    endfunction

    // Expected outputs per cycle after the start edge: two fetch cycles per entry,
    // then dur*T unpaused cycles of the note; end marker or slot 63 leads to one
    // END cycle and the song_end cycle, after which the sequencer sits idle.
    function automatic void build(input logic [1:0] sg, input int n0, input int p0);
        int c = 0;
        int n = n0;
        int p = p0;
        int need;
        int a = 0;
        logic [7:0] w;
        bit done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            a = sg * 64 + k;
            put(c, n, p, 0, a); c++;
            put(c, n, p, 0, a); c++;
            w = rom_mem[a];
            if (w[3:0] == 4'd0) begin
                done = 1;
            end else begin
                n = int'(w[7:4]);
                p = 1;
                need = int'(w[3:0]) * T;
                while (need > 0 && c < MAXC) begin
                    put(c, n, 1, 0, a);
                    if (!pz[c]) need--;
                    c++;
                end
            end
            if (done || k == 63) begin
                put(c, n, p, 0, a); c++;
                done = 1;
            end
        end
        put(c, 0, 0, 1, sg * 64); c++;
        while (c < MAXC) begin
            put(c, 0, 0, 0, sg * 64);
            c++;
        end
    endfunction

    // Pulses start for song sg, then records len cycles of outputs into o_vec.
    // pmode: 0 no pause, 1 pause in cycles 4..9, 2 random pause.
    task automatic play(input logic [1:0] sg, input int len, input int pmode);
        for (int c = 0; c < MAXC; c++) begin
            if (pmode == 0)      pz[c] = 0;
            else if (pmode == 1) pz[c] = (c >= 4 && c < 10);
            else                 pz[c] = ($urandom_range(0, 3) == 0);
        end
        build(sg, cur_note, cur_play);
        select = sg;
        start  = 1'b1;
        pause  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start  = 1'b0;
        select = 2'($urandom);
        for (int c = 0; c < len; c++) begin
            o_vec[c] = {rom_addr, note, playing, song_end};
            pause = pz[c];
            if (c < len - 1) begin
                @(posedge clk); #1;
            end
        end
        pause    = 1'b0;
        cur_note = int'(e_vec[len-1][5:2]);
        cur_play = int'(e_vec[len-1][1]);
    endtask

    task automatic fill_song2();
        int n = int'($urandom_range(2, 5));
        for (int k = 0; k < n; k++) rom_mem[128 + k] = {4'($urandom), 4'($urandom_range(1, 3))};
        rom_mem[128 + n] = {4'($urandom), 4'd0};
    endtask

    task automatic init_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0]  = {4'($urandom), 4'd0};
        rom_mem[64] = {4'd5, 4'd2};
        rom_mem[65] = {4'd9, 4'd1};
        rom_mem[66] = {4'($urandom), 4'd0};
        for (int k = 0; k < 64; k++) rom_mem[192 + k] = {4'($urandom), 4'd1};
        fill_song2();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0; select = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tests++;
        if ({rom_addr, note, playing, song_end} !== 14'd0) begin
            failed++;
            $display("FAIL reset: got %h, expected 0000 (addr,note,playing,song_end)",
                     {rom_addr, note, playing, song_end});
        end
        for (int c = 0; c < 6; c++) begin
            select = 2'($urandom);
            pause  = 1'($urandom);
            @(posedge clk); #1;
            tests++;
            if ({rom_addr, note, playing, song_end} !== 14'd0) begin
                failed++;
                $display("FAIL idle_hold cyc %0d: got %h, expected 0000", c,
                         {rom_addr, note, playing, song_end});
            end
        end
        pause = 1'b0;
        cur_note = 0;
        cur_play = 0;
    endtask

    task automatic test_song1();
        int ends = 0;
        play(2'd1, 24, 0);
        for (int c = 0; c < 24; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL song1 cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
            ends += int'(o_vec[c][0]);
        end
        tests++;
        if (ends !== 1) begin
            failed++;
            $display("FAIL song1_end_count: got %0d pulses, expected 1", ends);
        end
    endtask

    task automatic test_pause();
        play(2'd1, 30, 1);
        for (int c = 0; c < 30; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL pause cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_random_pause();
        for (int it = 0; it < 3; it++) begin
            fill_song2();
            play(2'd2, 120, 2);
            for (int c = 0; c < 120; c++) begin
                tests++;
                if (o_vec[c] !== e_vec[c]) begin
                    failed++;
                    $display("FAIL rand_pause it %0d cyc %0d: got %h, expected %h",
                             it, c, o_vec[c], e_vec[c]);
                end
            end
        end
    endtask

    task automatic test_restart();
        int k = int'($urandom_range(3, 9));
        play(2'd1, k, 0);
        for (int c = 0; c < k; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL restart_pre cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
        end
        play(2'd2, 20, 0);
        for (int c = 0; c < 20; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL restart_post cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        play(2'd1, 6, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if ({rom_addr, note, playing, song_end} !== 14'd0) begin
                failed++;
                $display("FAIL reset_mid cyc %0d: got %h, expected 0000", c,
                         {rom_addr, note, playing, song_end});
            end
            select = 2'($urandom);
            pause  = 1'($urandom);
            @(posedge clk); #1;
        end
        pause = 1'b0;
        cur_note = 0;
        cur_play = 0;
    endtask

    task automatic test_empty_song();
        play(2'd0, 10, 2);
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL empty cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_full_song();
        play(2'd3, 400, 0);
        for (int c = 0; c < 400; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL full cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    // Restart lands exactly on the END cycle, so the old song's end pulse must not appear.
    task automatic test_back_to_back();
        play(2'd1, 19, 0);
        for (int c = 0; c < 19; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL b2b_first cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
        end
        play(2'd1, 24, 0);
        for (int c = 0; c < 24; c++) begin
            tests++;
            if (o_vec[c] !== e_vec[c]) begin
                failed++;
                $display("FAIL b2b_second cyc %0d: got %h, expected %h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        pause  = 1'b0;
        select = 2'd0;
        cur_note = 0;
        cur_play = 0;
        init_rom();
        test_reset();
        test_song1();
        test_pause();
        test_random_pause();
        test_restart();
        test_reset_mid_play();
        test_empty_song();
        test_full_song();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Downstream consumer of the current-song selector.
- On a `start` pulse, latches the 2-bit song `select` and steps through that song's note table in an external synchronous ROM.
- Holds each note for its encoded duration in beats.
- At end of song, emits a one-cycle `song_end` pulse, which is wired back to the selector's `force_prox` to advance to the next song.

Parameters:
- NOTE_W, 4, width of the note code field in a ROM word.
- DUR_W, 4, width of the duration field (beats); value 0 is the end-of-song marker.
- IDX_W, 6, note index width per song; each song holds up to 2^IDX_W entries.
- TICKS_PER_BEAT, 12500000, clk cycles per beat; must be >= 2; bench uses 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- select  input  2  song number from selector; sampled only when start=1.
- start  input  1  begin/restart playback of song `select`.
- pause  input  1  level; freezes the beat timer while high.
- rom_addr  output  2+IDX_W  equals {song_reg, index_reg}; combinational from registers.
- rom_data  input  NOTE_W+DUR_W  valid the cycle after rom_addr; fields {note[NOTE_W-1:0], dur[DUR_W-1:0]}, note in the MSBs.
- note  output  NOTE_W  current note code; 0 = silence.
- playing  output  1  high while a note is being sounded.
- song_end  output  1  one-cycle pulse at end of song.

Behaviour:
- Reset (reset=1 at an edge) has priority over everything.
  - state=IDLE; song_reg=0, index_reg=0, tick_cnt=0, beat_cnt=0.
  - note=0, playing=0, song_end=0; hence rom_addr=0.
- States: IDLE, FETCH, WAIT, PLAY, END.
- start=1 (no reset), from any state:
  - song_reg<=select, index_reg<=0, tick_cnt<=0, state<=FETCH.
  - note and playing are unchanged this edge.
  - Overrides any other transition in the same cycle, including song_end generation.
- IDLE: hold; note=0, playing=0.
- FETCH: one cycle presenting rom_addr; next state is WAIT.
- WAIT: rom_data valid.
  - If dur==0: state<=END.
  - Else: note<=rom note, beat_cnt<=dur, tick_cnt<=0, playing<=1, state<=PLAY.
- Note changes 2 cycles after entering FETCH.
  - Previous note and playing are held through FETCH/WAIT, so there is no gap between consecutive notes.
- PLAY, pause=1: tick_cnt and beat_cnt hold; note and playing hold.
- PLAY, pause=0: tick_cnt increments.
  - At tick_cnt==TICKS_PER_BEAT-1: tick_cnt<=0 and beat_cnt<=beat_cnt-1.
  - If beat_cnt==1 at that edge, the note is finished.
- Note finished:
  - If index_reg==2^IDX_W-1: state<=END. No wrap; the table is full with no marker.
  - Else: index_reg<=index_reg+1, state<=FETCH.
- A note of dur=d occupies d*TICKS_PER_BEAT PLAY cycles, plus 2 fetch cycles before the next note appears.
- END, one cycle:
  - song_end=1 (registered, high exactly this cycle).
  - note<=0, playing<=0, index_reg<=0, state<=IDLE.
  - song_reg is retained.
- song_end is never high for two consecutive cycles.
- Widths:
  - tick_cnt is sized $clog2(TICKS_PER_BEAT).
  - beat_cnt is DUR_W bits.
  - index increment is unsigned, IDX_W bits.
- select changing without start has no effect.
- pause in non-PLAY states has no effect.

Test Plan:
- TICKS_PER_BEAT=4; ROM model with song 1 = {(5,2),(9,1),(x,0)}. reset, then select=01, start pulse:
  - rom_addr=0x40 in FETCH.
  - note=5, playing=1 two cycles after start edge, held 8 cycles plus 2 fetch cycles.
  - Then note=9 for 4 cycles.
  - Then song_end=1 for exactly one cycle, note=0, playing=0.
- Same song; pause=1 for 6 cycles during note 5 -> note 5 lasts 8+6 PLAY cycles; beat boundaries are delayed by 6.
- start with select=10 mid-note of song 1 -> rom_addr=0x80, and the first note of song 2 appears 2 cycles later. No song_end pulse for the aborted song 1.
- reset asserted mid-PLAY for one cycle -> next cycle note=0, playing=0, rom_addr=0, state IDLE. No song_end pulse.
- Song with first entry dur=0 -> song_end pulse 3 cycles after start edge; playing stays 0 throughout.
- Song 3 filled with 64 entries of dur=1 and no marker -> index advances 0..63, then song_end fires after the 64th note. rom_addr never wraps to 0xC0 within the song.
